// File: rtl/csr_irq_pkg.sv
// Shared CSR addresses, cause codes and bit positions for the machine-mode
// CSR / interrupt unit.
package csr_irq_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MBADADDR  = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
  localparam logic [11:0] CSR_XPEND     = 12'h7C1;
  localparam logic [11:0] CSR_XEN       = 12'h7C2;
  localparam logic [11:0] CSR_MTIME_WR  = 12'h7C3;
  localparam logic [11:0] CSR_MCYCLE    = 12'hF00;
  localparam logic [11:0] CSR_MTIME     = 12'hF01;
  localparam logic [11:0] CSR_MINSTRET  = 12'hF02;
  localparam logic [11:0] CSR_ID_LO     = 12'hF10;
  localparam logic [11:0] CSR_ID_HI     = 12'hF14;

  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER    = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT      = 4'd11;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MSTATUS_MPP  = 11;
  localparam int unsigned MIP_MTIP     = 7;
  localparam int unsigned MIP_MEIP     = 11;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_TRAP,
    EV_IRQ,
    EV_MRET
  } evt_e;

  // External interrupts take precedence over the timer when both are enabled.
  function automatic logic [3:0] irq_code(input logic ext_active);
    return ext_active ? CAUSE_M_EXT : CAUSE_M_TIMER;
  endfunction

endpackage

// File: rtl/csr_irq_unit_if.sv
// CSR access port: address, read/write strobes, write data and read-back.
interface csr_irq_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic [11:0]     cadr_i;
  logic            coe_i;
  logic            cwe_i;
  logic [XLEN-1:0] cdat_i;
  logic [XLEN-1:0] cdat_o;
  logic            cvalid_o;

  modport master (output cadr_i, coe_i, cwe_i, cdat_i, input cdat_o, cvalid_o);
  modport slave  (input cadr_i, coe_i, cwe_i, cdat_i, output cdat_o, cvalid_o);
endinterface

// File: rtl/csr_irq_unit_mtime_timer.sv
// Machine timer: prescaled mtime counter, mtimecmp and the MTIP compare.
module mtime_timer #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            i_mtime_we,
  input  logic            i_cmp_we,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_mtime,
  output logic [XLEN-1:0] o_mtimecmp,
  output logic            o_mtip_c
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]   r_presc;
  logic [XLEN-1:0] r_mtime;
  logic [XLEN-1:0] r_mtimecmp;
  logic            w_wrap;

  assign w_wrap = (r_presc == PW'(TICK_DIV - 1));

  // A software load of mtime restarts the prescaler and wins over the tick.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_presc    <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      if (i_mtime_we) begin
        r_mtime <= i_wdata;
        r_presc <= '0;
      end else if (w_wrap) begin
        r_mtime <= r_mtime + XLEN'(1);
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      if (i_cmp_we) r_mtimecmp <= i_wdata;
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_mtimecmp;
  assign o_mtip_c   = (r_mtime >= r_mtimecmp);
endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with trap entry/return, counters, external interrupt
// latching and the interrupt request to the sequencer.
module csr_irq_unit
  import csr_irq_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     NEXT_IRQ    = 8,
  parameter int unsigned     TICK_DIV    = 1,
  parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(64'hFFFF_FFFF_FFFF_FE00)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  csr_irq_unit_if.slave       csr,
  input  logic                trap_i,
  input  logic [3:0]          cause_i,
  input  logic [XLEN-1:0]     epc_i,
  input  logic [XLEN-1:0]     badaddr_i,
  input  logic                irq_take_i,
  input  logic                mret_i,
  input  logic                retire_i,
  input  logic [NEXT_IRQ-1:0] irq_i,
  output logic                irq_o,
  output logic [XLEN-1:0]     mtvec_o,
  output logic [XLEN-1:0]     mepc_o,
  output logic                mie_o,
  output logic                mpie_o,
  output logic [3:0]          cause_o
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic                r_mie, r_mpie, r_mtie, r_meie;
  logic [XLEN-1:0]     r_mtvec, r_mepc, r_mcause, r_mbadaddr, r_mscratch;
  logic [XLEN-1:0]     r_mcycle, r_minstret;
  logic [NEXT_IRQ-1:0] r_xpend, r_xen, r_irq_prev;

  logic [XLEN-1:0]     w_mtime, w_mtimecmp, w_rdata;
  logic [NEXT_IRQ-1:0] w_xclr;
  logic                w_mtip, w_meip, w_valid;
  evt_e                w_evt;

  mtime_timer #(.XLEN(XLEN), .TICK_DIV(TICK_DIV)) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .i_mtime_we (csr.cwe_i && (csr.cadr_i == CSR_MTIME_WR)),
    .i_cmp_we   (csr.cwe_i && (csr.cadr_i == CSR_MTIMECMP)),
    .i_wdata    (csr.cdat_i),
    .o_mtime    (w_mtime),
    .o_mtimecmp (w_mtimecmp),
    .o_mtip_c   (w_mtip)
  );

  assign w_meip = |(r_xpend & r_xen);
  assign w_xclr = (csr.cwe_i && (csr.cadr_i == CSR_XPEND)) ? csr.cdat_i[NEXT_IRQ-1:0] : '0;

  // Trap beats interrupt take, which beats trap return.
  always_comb begin
    w_evt = EV_NONE;
    if (trap_i)          w_evt = EV_TRAP;
    else if (irq_take_i) w_evt = EV_IRQ;
    else if (mret_i)     w_evt = EV_MRET;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mie <= 1'b0;  r_mpie <= 1'b1;  r_mtie <= 1'b0;  r_meie <= 1'b0;
      r_mtvec <= MTVEC_RESET;
      r_mepc <= '0;  r_mcause <= '0;  r_mbadaddr <= '0;  r_mscratch <= '0;
      r_mcycle <= '0;  r_minstret <= '0;
      r_xpend <= '0;  r_xen <= '0;  r_irq_prev <= '0;
    end else begin
      r_mcycle <= r_mcycle + XLEN'(1);
      if (retire_i) r_minstret <= r_minstret + XLEN'(1);
      r_irq_prev <= irq_i;
      r_xpend    <= (r_xpend & ~w_xclr) | (irq_i & ~r_irq_prev);
      if (csr.cwe_i) begin
        case (csr.cadr_i)
          CSR_MIE:      begin r_mtie <= csr.cdat_i[MIP_MTIP]; r_meie <= csr.cdat_i[MIP_MEIP]; end
          CSR_MTVEC:    r_mtvec    <= csr.cdat_i & ALIGN_MASK;
          CSR_MSCRATCH: r_mscratch <= csr.cdat_i;
          CSR_XEN:      r_xen      <= csr.cdat_i[NEXT_IRQ-1:0];
          default: ;
        endcase
      end
      case (w_evt)
        EV_TRAP: begin
          r_mepc     <= epc_i & ALIGN_MASK;
          r_mcause   <= XLEN'(cause_i);
          r_mbadaddr <= badaddr_i;
          r_mpie     <= r_mie;
          r_mie      <= 1'b0;
        end
        EV_IRQ: begin
          r_mepc   <= epc_i & ALIGN_MASK;
          r_mcause <= {1'b1, {(XLEN-5){1'b0}}, irq_code(w_meip && r_meie)};
          r_mpie   <= r_mie;
          r_mie    <= 1'b0;
        end
        EV_MRET: begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
        end
        default: begin
          if (csr.cwe_i) begin
            case (csr.cadr_i)
              CSR_MSTATUS:  begin r_mie <= csr.cdat_i[MSTATUS_MIE]; r_mpie <= csr.cdat_i[MSTATUS_MPIE]; end
              CSR_MEPC:     r_mepc     <= csr.cdat_i & ALIGN_MASK;
              CSR_MCAUSE:   r_mcause   <= csr.cdat_i;
              CSR_MBADADDR: r_mbadaddr <= csr.cdat_i;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Combinational read mux; identification registers read as zero.
  always_comb begin
    w_rdata = '0;
    w_valid = 1'b1;
    case (csr.cadr_i)
      CSR_MSTATUS: begin
        w_rdata[MSTATUS_MIE]     = r_mie;
        w_rdata[MSTATUS_MPIE]    = r_mpie;
        w_rdata[MSTATUS_MPP +: 2] = 2'b11;
      end
      CSR_MIE:      begin w_rdata[MIP_MTIP] = r_mtie; w_rdata[MIP_MEIP] = r_meie; end
      CSR_MIP:      begin w_rdata[MIP_MTIP] = w_mtip; w_rdata[MIP_MEIP] = w_meip; end
      CSR_MTVEC:    w_rdata = r_mtvec;
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = r_mepc;
      CSR_MCAUSE:   w_rdata = r_mcause;
      CSR_MBADADDR: w_rdata = r_mbadaddr;
      CSR_MTIMECMP: w_rdata = w_mtimecmp;
      CSR_XPEND:    w_rdata = XLEN'(r_xpend);
      CSR_XEN:      w_rdata = XLEN'(r_xen);
      CSR_MTIME_WR: w_rdata = w_mtime;
      CSR_MCYCLE:   w_rdata = r_mcycle;
      CSR_MTIME:    w_rdata = w_mtime;
      CSR_MINSTRET: w_rdata = r_minstret;
      default:      w_valid = (csr.cadr_i >= CSR_ID_LO) && (csr.cadr_i <= CSR_ID_HI);
    endcase
  end

  assign csr.cdat_o   = (w_valid && csr.coe_i) ? w_rdata : '0;
  assign csr.cvalid_o = w_valid;

  assign irq_o   = r_mie & ((r_meie & w_meip) | (r_mtie & w_mtip));
  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign mie_o   = r_mie;
  assign mpie_o  = r_mpie;
  assign cause_o = r_mcause[3:0];
endmodule

// File: tb/tb_csr_irq_unit.sv
// Bench for csr_irq_unit: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the CSR/interrupt rules.
module tb_csr_irq_unit;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NIRQ = 8;
  localparam int unsigned TD   = 4;
  localparam logic [63:0] MTVEC_RST = 64'hFFFF_FFFF_FFFF_FE00;
  localparam logic [63:0] ONES      = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, trap, take, mret, retire;
  logic [3:0]  cause;
  logic [63:0] epc, bad;
  logic [7:0]  irq;
  logic        irq_o, mie_o, mpie_o;
  logic [63:0] mtvec_o, mepc_o;
  logic [3:0]  cause_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  csr_irq_unit_if #(.XLEN(XLEN)) bus ();

  csr_irq_unit #(.XLEN(XLEN), .NEXT_IRQ(NIRQ), .TICK_DIV(TD), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk_i(clk), .reset_i(reset), .csr(bus),
    .trap_i(trap), .cause_i(cause), .epc_i(epc), .badaddr_i(bad),
    .irq_take_i(take), .mret_i(mret), .retire_i(retire), .irq_i(irq),
    .irq_o(irq_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
    .mie_o(mie_o), .mpie_o(mpie_o), .cause_o(cause_o)
  );

  // ---------------- behavioural model ----------------
  logic            m_ok = 1'b0;
  logic            m_mie, m_mpie, m_mtie, m_meie;
  logic [63:0]     m_mtvec, m_mepc, m_mcause, m_mbad, m_mscratch, m_cmp;
  logic [63:0]     m_mcycle, m_minstret, m_tbase;
  longint unsigned m_tcnt;
  logic [7:0]      m_xpend, m_xen, m_prev;

  // mtime is the last loaded value plus one per TD cycles elapsed since the load
  function automatic logic [63:0] m_mtime();
    return m_tbase + 64'(m_tcnt / TD);
  endfunction
  function automatic logic m_mtip(); return m_mtime() >= m_cmp; endfunction
  function automatic logic m_meip(); return |(m_xpend & m_xen); endfunction
  function automatic logic m_irq();
    return m_mie & ((m_meie & m_meip()) | (m_mtie & m_mtip()));
  endfunction
  function automatic logic wen(input logic [11:0] a);
    return bus.cwe_i && (bus.cadr_i == a);
  endfunction

  function automatic logic m_valid(input logic [11:0] a);
    return (a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                      12'h344, 12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'hF00, 12'hF01,
                      12'hF02}) || (a >= 12'hF10 && a <= 12'hF14);
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    logic [63:0] v;
    v = 64'h0;
    case (a)
      12'h300: begin v[3] = m_mie; v[7] = m_mpie; v[12:11] = 2'b11; end
      12'h304: begin v[7] = m_mtie; v[11] = m_meie; end
      12'h344: begin v[7] = m_mtip(); v[11] = m_meip(); end
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mbad;
      12'h7C0: v = m_cmp;
      12'h7C1: v = {56'h0, m_xpend};
      12'h7C2: v = {56'h0, m_xen};
      12'h7C3, 12'hF01: v = m_mtime();
      12'hF00: v = m_mcycle;
      12'hF02: v = m_minstret;
      default: v = 64'h0;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok <= 1'b1;
      m_mie <= 1'b0; m_mpie <= 1'b1; m_mtie <= 1'b0; m_meie <= 1'b0;
      m_mtvec <= MTVEC_RST; m_mepc <= '0; m_mcause <= '0; m_mbad <= '0; m_mscratch <= '0;
      m_cmp <= ONES; m_mcycle <= '0; m_minstret <= '0; m_tbase <= '0; m_tcnt <= 0;
      m_xpend <= '0; m_xen <= '0; m_prev <= '0;
    end else if (m_ok) begin
      m_mcycle <= m_mcycle + 64'd1;
      if (retire) m_minstret <= m_minstret + 64'd1;
      if (wen(12'h7C3)) begin m_tbase <= bus.cdat_i; m_tcnt <= 0; end
      else m_tcnt <= m_tcnt + 1;
      if (wen(12'h7C0)) m_cmp <= bus.cdat_i;
      if (wen(12'h304)) begin m_mtie <= bus.cdat_i[7]; m_meie <= bus.cdat_i[11]; end
      if (wen(12'h305)) m_mtvec <= bus.cdat_i & ~64'h3;
      if (wen(12'h340)) m_mscratch <= bus.cdat_i;
      if (wen(12'h7C2)) m_xen <= bus.cdat_i[7:0];
      m_xpend <= (m_xpend & ~(wen(12'h7C1) ? bus.cdat_i[7:0] : 8'h0)) | (irq & ~m_prev);
      m_prev  <= irq;
      if (trap) begin
        m_mepc <= epc & ~64'h3; m_mcause <= {60'h0, cause}; m_mbad <= bad;
        m_mpie <= m_mie; m_mie <= 1'b0;
      end else if (take) begin
        m_mepc   <= epc & ~64'h3;
        m_mcause <= {1'b1, 59'h0, (m_meip() && m_meie) ? 4'd11 : 4'd7};
        m_mpie <= m_mie; m_mie <= 1'b0;
      end else if (mret) begin
        m_mie <= m_mpie; m_mpie <= 1'b1;
      end else begin
        if (wen(12'h300)) begin m_mie <= bus.cdat_i[3]; m_mpie <= bus.cdat_i[7]; end
        if (wen(12'h341)) m_mepc <= bus.cdat_i & ~64'h3;
        if (wen(12'h342)) m_mcause <= bus.cdat_i;
        if (wen(12'h343)) m_mbad <= bus.cdat_i;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    if (!m_ok) return;
    chk("cvalid", 64'(bus.cvalid_o), 64'(m_valid(bus.cadr_i)));
    chk("cdat", bus.cdat_o, (m_valid(bus.cadr_i) && bus.coe_i) ? m_read(bus.cadr_i) : 64'h0);
    chk("irq_o", 64'(irq_o), 64'(m_irq()));
    chk("mtvec_o", mtvec_o, m_mtvec);
    chk("mepc_o", mepc_o, m_mepc);
    chk("mie_o", 64'(mie_o), 64'(m_mie));
    chk("mpie_o", 64'(mpie_o), 64'(m_mpie));
    chk("cause_o", 64'(cause_o), 64'(m_mcause[3:0]));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    reset = 1'b0; trap = 1'b0; take = 1'b0; mret = 1'b0; retire = 1'b0;
    cause = 4'h0; epc = '0; bad = '0; irq = '0;
    bus.cadr_i = 12'h000; bus.coe_i = 1'b1; bus.cwe_i = 1'b0; bus.cdat_i = '0;
  endtask
  task automatic next(); @(negedge clk); clr(); endtask
  task automatic settle(); #1; cmp_all(); endtask
  task automatic idle(); next(); settle(); endtask
  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    next(); bus.cwe_i = 1'b1; bus.cadr_i = a; bus.cdat_i = d; settle();
  endtask
  task automatic rd(input string name, input logic [11:0] a, input logic [63:0] exp);
    next(); bus.cadr_i = a; settle(); chk(name, bus.cdat_o, exp);
  endtask
  task automatic do_reset();
    next(); reset = 1'b1; settle();
    idle();
  endtask

  logic [11:0] addrs [20];

  initial begin
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
              12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'hF00, 12'hF01, 12'hF02, 12'hF12,
              12'h000, 12'h7C4, 12'hF15, 12'h345};
    clr();
    do_reset();

    // reset values
    rd("rst_mtvec", 12'h305, MTVEC_RST);
    rd("rst_mstatus", 12'h300, 64'h1880);
    rd("rst_mtimecmp", 12'h7C0, ONES);
    chk("rst_irq", 64'(irq_o), 64'h0);
    chk("rst_cause", 64'(cause_o), 64'h0);

    // timer interrupt with TD=4, then interrupt take
    wr(12'h7C0, 64'd3); wr(12'h304, 64'h80); wr(12'h300, 64'h8); wr(12'h7C3, 64'h0);
    for (int k = 0; k < 12; k++) begin idle(); chk("tmr_irq_low", 64'(irq_o), 64'h0); end
    idle(); chk("tmr_irq_high", 64'(irq_o), 64'h1);
    next(); take = 1'b1; epc = 64'h1000; settle();
    idle();
    chk("take_mepc", mepc_o, 64'h1000);
    chk("take_mie", 64'(mie_o), 64'h0);
    chk("take_mpie", 64'(mpie_o), 64'h1);
    chk("take_irq", 64'(irq_o), 64'h0);
    rd("take_mcause", 12'h342, 64'h8000_0000_0000_0007);

    // external edge latching and write-one-to-clear
    do_reset();
    wr(12'h7C2, 64'h04);
    next(); irq = 8'h04; settle();
    idle();
    rd("xpend_set", 12'h7C1, 64'h04);
    rd("mip_meip", 12'h344, 64'h800);
    wr(12'h7C1, 64'h04);
    rd("xpend_clr", 12'h7C1, 64'h0);
    next(); irq = 8'h04; bus.cwe_i = 1'b1; bus.cadr_i = 12'h7C1; bus.cdat_i = 64'h04; settle();
    idle();
    rd("xpend_set_wins", 12'h7C1, 64'h04);

    // external over timer, trap over interrupt take, mret restores
    do_reset();
    wr(12'h7C2, 64'h04);
    next(); irq = 8'h04; settle();
    idle();
    wr(12'h7C0, 64'h0); wr(12'h304, 64'h880); wr(12'h300, 64'h8);
    idle(); chk("both_irq", 64'(irq_o), 64'h1);
    next(); take = 1'b1; epc = 64'h2000; settle();
    rd("ext_code", 12'h342, 64'h8000_0000_0000_000B);
    wr(12'h300, 64'h8);
    next(); trap = 1'b1; cause = 4'd2; take = 1'b1; epc = 64'h3000; settle();
    rd("trap_wins", 12'h342, 64'h2);
    chk("trap_cause_o", 64'(cause_o), 64'h2);
    chk("trap_mepc", mepc_o, 64'h3000);
    chk("trap_irq_low", 64'(irq_o), 64'h0);
    next(); mret = 1'b1; settle();
    idle(); chk("mret_irq", 64'(irq_o), 64'h1);

    // trap beats a same-cycle CSR write to mepc
    next(); trap = 1'b1; cause = 4'd3; epc = 64'h4000;
    bus.cwe_i = 1'b1; bus.cadr_i = 12'h341; bus.cdat_i = 64'h5550; settle();
    idle(); chk("trap_vs_wr", mepc_o, 64'h4000);
    rd("trap_vs_wr_cause", 12'h342, 64'h3);

    // mtime wrap from all ones
    do_reset();
    wr(12'h7C0, 64'd5); wr(12'h7C3, ONES);
    rd("mtime_ones", 12'hF01, ONES);
    rd("mtip_ones", 12'h344, 64'h80);
    idle(); idle();
    rd("mtime_wrap", 12'hF01, 64'h0);
    rd("mtip_clr", 12'h344, 64'h0);

    // random traffic against the model
    for (int it = 0; it < 4000; it++) begin
      int ev;
      next();
      reset  = ($urandom_range(0, 299) == 0);
      retire = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      bus.cadr_i = addrs[$urandom_range(0, 19)];
      ev = $urandom_range(0, 24);
      cause = 4'($urandom);
      epc   = {$urandom, $urandom} & ~64'h3;
      bad   = {$urandom, $urandom};
      case (ev)
        0: trap = 1'b1;
        1, 2: take = 1'b1;
        3: mret = 1'b1;
        4: begin trap = 1'b1; take = 1'b1; end
        5: begin take = 1'b1; mret = 1'b1; end
        default: if ($urandom_range(0, 9) < 4) begin
          bus.cwe_i  = 1'b1;
          bus.cdat_i = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 40))
                                                   : {$urandom, $urandom};
        end
      endcase
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
